// File: rtl/cv32e40p_regfile_err_handler.sv
// Register-file parity error handler.
// Qualifies parity errors on three read ports, captures the first faulty
// address/port, raises a level interrupt until acknowledged, flags overflow,
// and keeps a saturating error count with a sticky fatal threshold flag.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rvalid_i[2:0], perr_i[2:0]    per-port read valid / parity mismatch (A/B/C)
//   raddr_a_i/_b_i/_c_i           per-port read address
//   ack_i, clear_i                interrupt acknowledge, error counter clear
//   irq_o, err_addr_o, err_port_o interrupt and captured error location
//   overflow_o, err_count_o       lost-error flag, saturating error count
//   fatal_o                       sticky threshold-reached flag
module cv32e40p_regfile_err_handler #(
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned CNT_WIDTH       = 8,
  parameter int unsigned FATAL_THRESHOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            rvalid_i,
  input  logic [2:0]            perr_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  irq_o,
  input  logic                  ack_i,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [1:0]            err_port_o,
  output logic                  overflow_o,
  output logic [CNT_WIDTH-1:0]  err_count_o,
  input  logic                  clear_i,
  output logic                  fatal_o
);

  // Two spare bits cover count + 3 before saturation.
  localparam int unsigned SUM_W = CNT_WIDTH + 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            qerr;
  logic                  any_err;
  logic [1:0]            nerr;
  logic [1:0]            sel_port;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ADDR_WIDTH-1:0] err_addr_d;
  logic [1:0]            err_port_d;
  logic                  overflow_d;
  logic [SUM_W-1:0]      sum;
  logic [CNT_WIDTH-1:0]  count_d;
  logic                  fatal_d;

  // Error qualification, population count and lowest-index port select.
  always_comb begin
    qerr     = rvalid_i & perr_i;
    nerr     = 2'(qerr[0]) + 2'(qerr[1]) + 2'(qerr[2]);
    sel_port = 2'd0;
    sel_addr = raddr_a_i;
    if (qerr[0]) begin
      sel_port = 2'd0;
      sel_addr = raddr_a_i;
    end else if (qerr[1]) begin
      sel_port = 2'd1;
      sel_addr = raddr_b_i;
    end else if (qerr[2]) begin
      sel_port = 2'd2;
      sel_addr = raddr_c_i;
    end
  end

  assign any_err = |qerr;

  // State register; irq_o is the registered PENDING indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      irq_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_o   <= (state_d == PENDING);
    end
  end

  // Next-state, capture and overflow logic.
  always_comb begin
    state_d    = state_q;
    err_addr_d = err_addr_o;
    err_port_d = err_port_o;
    overflow_d = overflow_o;
    case (state_q)
      IDLE: begin
        if (any_err) begin
          state_d    = PENDING;
          err_addr_d = sel_addr;
          err_port_d = sel_port;
          overflow_d = 1'b0;
        end
      end
      PENDING: begin
        if (ack_i) begin
          // Ack with a fresh error re-arms on the new capture without an irq gap.
          overflow_d = 1'b0;
          if (any_err) begin
            err_addr_d = sel_addr;
            err_port_d = sel_port;
          end else begin
            state_d = IDLE;
          end
        end else if (any_err) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating counter; clear loads this cycle's count. Fatal uses the
  // registered count, so it rises one cycle after the threshold is seen.
  always_comb begin
    sum = clear_i ? SUM_W'(nerr) : (SUM_W'(err_count_o) + SUM_W'(nerr));
    if (sum > SUM_W'({CNT_WIDTH{1'b1}})) begin
      count_d = {CNT_WIDTH{1'b1}};
    end else begin
      count_d = CNT_WIDTH'(sum);
    end
    fatal_d = fatal_o | (32'(err_count_o) >= 32'(FATAL_THRESHOLD));
  end

  // Capture, overflow, counter and fatal registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr_o  <= '0;
      err_port_o  <= 2'd0;
      overflow_o  <= 1'b0;
      err_count_o <= '0;
      fatal_o     <= 1'b0;
    end else begin
      err_addr_o  <= err_addr_d;
      err_port_o  <= err_port_d;
      overflow_o  <= overflow_d;
      err_count_o <= count_d;
      fatal_o     <= fatal_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_regfile_err_handler.sv
// Testbench for cv32e40p_regfile_err_handler.
// Two instances share all inputs: default parameters (8-bit count) and
// CNT_WIDTH=2. A behavioural model tracks expected outputs for both; every
// cycle all outputs are compared, plus directed literal expectations.
module tb_cv32e40p_regfile_err_handler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rvalid_i = 3'b000;
  logic [2:0] perr_i = 3'b000;
  logic [5:0] raddr_a_i = 6'h00;
  logic [5:0] raddr_b_i = 6'h00;
  logic [5:0] raddr_c_i = 6'h00;
  logic       ack_i = 1'b0;
  logic       clear_i = 1'b0;

  logic       irq0, ovf0, fatal0;
  logic [5:0] addr0;
  logic [1:0] port0;
  logic [7:0] cnt0;
  logic       irq1, ovf1, fatal1;
  logic [5:0] addr1;
  logic [1:0] port1;
  logic [1:0] cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cv32e40p_regfile_err_handler dut (
    .clk(clk), .rst(rst), .rvalid_i(rvalid_i), .perr_i(perr_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
    .irq_o(irq0), .ack_i(ack_i), .err_addr_o(addr0), .err_port_o(port0),
    .overflow_o(ovf0), .err_count_o(cnt0), .clear_i(clear_i), .fatal_o(fatal0)
  );

  cv32e40p_regfile_err_handler #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .rvalid_i(rvalid_i), .perr_i(perr_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
    .irq_o(irq1), .ack_i(ack_i), .err_addr_o(addr1), .err_port_o(port1),
    .overflow_o(ovf1), .err_count_o(cnt1), .clear_i(clear_i), .fatal_o(fatal1)
  );

  // ---------------- behavioural model ----------------
  int m_pend, m_addr, m_port, m_ovf;
  int m_cnt8, m_cnt2, m_fatal8, m_fatal2;
  logic [2:0] q_m;
  int n_m;

  assign q_m = rvalid_i & perr_i;
  assign n_m = $countones(q_m);

  function automatic int lowest(input logic [2:0] q);
    if (q[0]) return 0;
    if (q[1]) return 1;
    return 2;
  endfunction

  function automatic int addr_of(input int p);
    if (p == 0) return int'(raddr_a_i);
    if (p == 1) return int'(raddr_b_i);
    return int'(raddr_c_i);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 0; m_addr <= 0; m_port <= 0; m_ovf <= 0;
      m_cnt8 <= 0; m_cnt2 <= 0; m_fatal8 <= 0; m_fatal2 <= 0;
    end else begin
      m_fatal8 <= (m_fatal8 != 0 || m_cnt8 >= 16) ? 1 : 0;
      m_fatal2 <= (m_fatal2 != 0 || m_cnt2 >= 16) ? 1 : 0;
      m_cnt8   <= sat(clear_i ? n_m : m_cnt8 + n_m, 255);
      m_cnt2   <= sat(clear_i ? n_m : m_cnt2 + n_m, 3);
      if (q_m != 3'b000) begin
        if (m_pend == 0 || ack_i) begin
          m_port <= lowest(q_m);
          m_addr <= addr_of(lowest(q_m));
          m_ovf  <= 0;
        end else begin
          m_ovf <= 1;
        end
        m_pend <= 1;
      end else if (m_pend != 0 && ack_i) begin
        m_pend <= 0;
        m_ovf  <= 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("irq",      32'(irq0),   32'(m_pend));
    chk("addr",     32'(addr0),  32'(m_addr));
    chk("port",     32'(port0),  32'(m_port));
    chk("overflow", 32'(ovf0),   32'(m_ovf));
    chk("count",    32'(cnt0),   32'(m_cnt8));
    chk("fatal",    32'(fatal0), 32'(m_fatal8));
    chk("w2.irq",   32'(irq1),   32'(m_pend));
    chk("w2.addr",  32'(addr1),  32'(m_addr));
    chk("w2.port",  32'(port1),  32'(m_port));
    chk("w2.ovf",   32'(ovf1),   32'(m_ovf));
    chk("w2.count", 32'(cnt1),   32'(m_cnt2));
    chk("w2.fatal", 32'(fatal1), 32'(m_fatal2));
  endtask

  // Advance to the next falling edge and compare everything against the model.
  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [2:0] rv, input logic [2:0] pe,
                       input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                       input logic ack, input logic clr);
    rvalid_i = rv; perr_i = pe;
    raddr_a_i = a; raddr_b_i = b; raddr_c_i = c;
    ack_i = ack; clear_i = clr;
  endtask

  task automatic idle();
    drive(3'b000, 3'b000, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".irq"},   32'(irq0),   0);
    chk({tag, ".addr"},  32'(addr0),  0);
    chk({tag, ".port"},  32'(port0),  0);
    chk({tag, ".ovf"},   32'(ovf0),   0);
    chk({tag, ".count"}, 32'(cnt0),   0);
    chk({tag, ".fatal"}, 32'(fatal0), 0);
    chk({tag, ".w2irq"}, 32'(irq1),   0);
    chk({tag, ".w2cnt"}, 32'(cnt1),   0);
    chk({tag, ".w2addr"},32'(addr1),  0);
    chk({tag, ".w2port"},32'(port1),  0);
    chk({tag, ".w2ovf"}, 32'(ovf1),   0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Single error on B.
    drive(3'b010, 3'b010, 6'h00, 6'h25, 6'h00, 1'b0, 1'b0);
    step();
    chk("b_err.irq", 32'(irq0), 1);
    chk("b_err.addr", 32'(addr0), 32'h25);
    chk("b_err.port", 32'(port0), 1);
    chk("b_err.count", 32'(cnt0), 1);
    drive(3'b000, 3'b000, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0);
    step();
    chk("ack.irq", 32'(irq0), 0);
    chk("ack.addr_hold", 32'(addr0), 32'h25);

    // Ack in IDLE is ignored.
    drive(3'b000, 3'b000, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0);
    step();
    chk("idle_ack.irq", 32'(irq0), 0);

    // B and C together; A valid without parity error; B wins.
    drive(3'b111, 3'b110, 6'h3A, 6'h03, 6'h07, 1'b0, 1'b0);
    step();
    chk("bc.port", 32'(port0), 1);
    chk("bc.addr", 32'(addr0), 32'h03);
    chk("bc.count", 32'(cnt0), 3);

    // perr without rvalid is not an error.
    drive(3'b000, 3'b111, 6'h01, 6'h02, 6'h04, 1'b0, 1'b0);
    step();
    chk("novalid.count", 32'(cnt0), 3);

    // Overflow while pending.
    drive(3'b001, 3'b001, 6'h11, 6'h00, 6'h00, 1'b0, 1'b0);
    step();
    chk("ovf.addr", 32'(addr0), 32'h03);
    chk("ovf.port", 32'(port0), 1);
    chk("ovf.flag", 32'(ovf0), 1);
    chk("ovf.w2sat", 32'(cnt1), 3);
    drive(3'b000, 3'b000, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0);
    step();
    chk("ack2.irq", 32'(irq0), 0);
    chk("ack2.ovf", 32'(ovf0), 0);

    // Ack coinciding with a new error on C.
    drive(3'b001, 3'b001, 6'h0A, 6'h00, 6'h00, 1'b0, 1'b0);
    step();
    drive(3'b010, 3'b010, 6'h00, 6'h12, 6'h00, 1'b0, 1'b0);
    step();
    chk("pre_ack.ovf", 32'(ovf0), 1);
    drive(3'b100, 3'b100, 6'h00, 6'h00, 6'h3F, 1'b1, 1'b0);
    step();
    chk("ackerr.irq", 32'(irq0), 1);
    chk("ackerr.addr", 32'(addr0), 32'h3F);
    chk("ackerr.port", 32'(port0), 2);
    chk("ackerr.ovf", 32'(ovf0), 0);
    chk("ackerr.count", 32'(cnt0), 7);
    drive(3'b000, 3'b000, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0);
    step();

    // Fatal threshold.
    drive(3'b000, 3'b000, 6'h00, 6'h00, 6'h00, 1'b0, 1'b1);
    step();
    chk("clr.count", 32'(cnt0), 0);
    for (int i = 0; i < 16; i++) begin
      drive(3'b001, 3'b001, 6'(i), 6'h00, 6'h00, 1'b0, 1'b0);
      step();
    end
    chk("thr.count", 32'(cnt0), 16);
    chk("thr.fatal_early", 32'(fatal0), 0);
    idle();
    step();
    chk("thr.fatal", 32'(fatal0), 1);
    drive(3'b001, 3'b001, 6'h05, 6'h00, 6'h00, 1'b0, 1'b1);
    step();
    chk("clr_inc.count", 32'(cnt0), 1);
    chk("clr_inc.fatal", 32'(fatal0), 1);

    // Narrow counter saturation, then reset while pending.
    drive(3'b000, 3'b000, 6'h00, 6'h00, 6'h00, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(3'b100, 3'b100, 6'h00, 6'h00, 6'(i + 8), 1'b0, 1'b0);
      step();
    end
    chk("w2.sat", 32'(cnt1), 3);
    chk("w2.full", 32'(cnt0), 5);
    chk("w2.pend", 32'(irq1), 1);
    idle();
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    step();
    rst = 1'b0;

    // Wide counter saturation at 255.
    for (int i = 0; i < 100; i++) begin
      drive(3'b111, 3'b111, 6'(i), 6'(i + 1), 6'(i + 2), 1'b0, 1'b0);
      step();
    end
    chk("sat255", 32'(cnt0), 255);
    chk("sat255.fatal", 32'(fatal0), 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(3'($urandom), 3'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
            ($urandom_range(3) == 0), ($urandom_range(31) == 0));
      if ($urandom_range(2) != 0) perr_i = 3'b000;
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
